uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Byte FIFO between the CPU core's UART transmit outputs (uart_tx_data/uart_tx_valid) and the UART
//   interface's transmit inputs (tx_data_in/tx_valid_in). Decouples CPU bursts from line-rate drain.
//   valid/ready handshake on both sides; occupancy, almost-full and sticky overflow status for debug/CPU.
// PARAMETERS
//   DATA_WIDTH    8    width of each stored byte/word
//   DEPTH         16   entries; power of 2, >= 4
//   AFULL_THRESH  12   almost_full asserts when count >= AFULL_THRESH; 1..DEPTH
// PORTS
//   clk          in   1                    single clock; all state on rising edge
//   reset        in   1                    asynchronous, active-high; clears all state immediately
//   clear        in   1                    synchronous flush of contents and overflow flag
//   wr_data      in   DATA_WIDTH           byte from cpu_core
//   wr_valid     in   1                    write request
//   wr_ready     out  1                    FIFO can accept (not full)
//   rd_data      out  DATA_WIDTH           head entry to uart_if
//   rd_valid     out  1                    head entry valid (FIFO not empty)
//   rd_ready     in   1                    uart_if consumes head this cycle
//   count        out  $clog2(DEPTH)+1      current occupancy, 0..DEPTH
//   almost_full  out  1                    count >= AFULL_THRESH
//   overflow     out  1                    sticky: write attempted while full
// BEHAVIOUR
//   - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, overflow=0; outputs rd_valid=0,
//     rd_data=0, wr_ready=1, almost_full=0. Storage array not reset.
//   - Write accepted in a cycle iff wr_valid && wr_ready; data stored at wr_ptr, wr_ptr+1 mod DEPTH.
//   - Read accepted in a cycle iff rd_valid && rd_ready; rd_ptr+1 mod DEPTH.
//   - First-word-fall-through: rd_data = mem[rd_ptr] whenever rd_valid=1; rd_data forced to 0 when
//     rd_valid=0. Latency: byte accepted at edge N is on rd_data with rd_valid=1 after edge N
//     (visible cycle N+1) when FIFO was empty.
//   - rd_valid = (count != 0); wr_ready = (count != DEPTH). wr_ready does NOT depend on rd_ready:
//     when full, a write is refused even if a read completes in the same cycle.
//   - Simultaneous accepted write+read: count unchanged, both pointers advance.
//   - Empty: rd_ready ignored, no pointer/count change. Full: wr_valid ignored for storage.
//   - Pointer wrap: DEPTH-1 -> 0 on both pointers; count distinguishes full from empty.
//   - overflow: set on the edge where wr_valid=1 && count==DEPTH; held until clear or reset.
//   - almost_full, count, rd_valid, wr_ready derived from registered count (no comb. path from inputs).
//   - clear=1: next state pointers=0, count=0, overflow=0; overrides any write/read/overflow set in
//     the same cycle (that write is discarded, that read is not counted).
//   - reset mid-transfer: contents lost; rd_valid drops immediately (asynchronously) with reset.
//   - rd_ready/wr_valid values while reset asserted are ignored.
// TESTING
//   1 Reset then write 0xA5: rd_valid=0 in write cycle, next cycle rd_valid=1, rd_data=0xA5,
//     count=1; pulse rd_ready -> rd_valid=0, count=0, rd_data=0.
//   2 Write 16 bytes 0x00..0x0F with rd_ready=0: almost_full=1 from count=12, wr_ready=0 at
//     count=16; 17th write (0xFF) -> overflow=1, count stays 16; drain yields 0x00..0x0F in order.
//   3 Full FIFO, wr_valid=1 and rd_ready=1 same cycle: read completes, write refused, count=15,
//     overflow=1; next cycle write accepted, count=16.
//   4 Wrap: 10 writes/10 reads, then 12 writes 0x40..0x4B interleaved with continuous reads
//     (wr+rd every cycle at count=1): count holds at 1, output order preserved across pointer wrap.
//   5 count=5 and overflow=1, assert clear together with wr_valid: next cycle count=0, rd_valid=0,
//     overflow=0, written byte absent.
//   6 Assert reset asynchronously mid-cycle with count=7: rd_valid, count, almost_full drop before
//     the next clk edge; after release wr_ready=1 and a new write appears normally.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Handshake and status bundle between cpu_core (write side), uart_if (read side) and the TX byte FIFO.
// The slave modport belongs to the FIFO. The master modport belongs to whoever drives the FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  clear;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [CW-1:0]         count;
    logic                  almost_full;
    logic                  overflow;

    modport slave (
        input  clear, wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid, count, almost_full, overflow
    );

    modport master (
        output clear, wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid, count, almost_full, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO that decouples CPU transmit bursts from the UART line-rate drain.
// It also reports occupancy, almost-full and a sticky overflow flag.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic full, empty, wr_fire, rd_fire;

    // All status comes from registered count. This means async reset drops rd_valid at once.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_fire = bus.wr_valid && !full;
    assign rd_fire = bus.rd_ready && !empty;

    assign bus.wr_ready    = !full;
    assign bus.rd_valid    = !empty;
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= CW'(AFULL_THRESH));
    assign bus.overflow    = overflow_q;
    assign bus.rd_data     = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (bus.wr_valid && full) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset. A write discarded by clear never lands.
    always_ff @(posedge clk) begin
        if (wr_fire && !bus.clear && !reset) mem_q[wr_ptr_q] <= bus.wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic compared against a queue model.
module tb_uart_tx_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors    = 0;
    int   miscompares = 0;

    logic [DW-1:0] model_q [$];
    bit            model_ovf;

    uart_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] exp_data;
        exp_data = (model_q.size() != 0) ? model_q[0] : '0;
        check({tag, ".count"},    32'(bus.count),       32'(model_q.size()));
        check({tag, ".rd_valid"}, 32'(bus.rd_valid),    32'(model_q.size() != 0));
        check({tag, ".wr_ready"}, 32'(bus.wr_ready),    32'(model_q.size() != DEPTH));
        check({tag, ".afull"},    32'(bus.almost_full), 32'(model_q.size() >= AF));
        check({tag, ".ovf"},      32'(bus.overflow),    32'(model_ovf));
        check({tag, ".rd_data"},  32'(bus.rd_data),     32'(exp_data));
    endtask

    // Applies one cycle of inputs, advances the model by the FIFO rules, then checks after the edge.
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit clr,
                        input string tag);
        bit full, empty;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        bus.clear    = clr;
        full  = (model_q.size() == DEPTH);
        empty = (model_q.size() == 0);
        if (clr) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (rr && !empty) void'(model_q.pop_front());
            if (wv && full) model_ovf = 1'b1;
            if (wv && !full) model_q.push_back(wd);
        end
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.clear    = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.clear    = 1'b0;
        model_ovf    = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_outputs("reset");

        // Single byte round trip
        step(1'b1, 8'hA5, 1'b0, 1'b0, "t1_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t1_rd");

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "t2_fill");
        step(1'b1, 8'hFF, 1'b0, 1'b0, "t2_ovf");
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t2_drain");

        // Full, write and read together: the read completes and the write is refused
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "t3_fill");
        step(1'b1, 8'h77, 1'b1, 1'b0, "t3_both");
        step(1'b1, 8'h78, 1'b0, 1'b0, "t3_refill");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t3_clear");

        // Wrap the pointers with continuous read and write traffic
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "t4_w");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t4_r");
        step(1'b1, 8'h40, 1'b0, 1'b0, "t4_first");
        for (int i = 1; i < 12; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, "t4_stream");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t4_last");

        // Clear overrides a same-cycle write and also clears overflow
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, "t5_fill");
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t5_drain");
        step(1'b1, 8'hEE, 1'b0, 1'b1, "t5_clear");

        // Async reset mid-cycle with 7 entries
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "t6_fill");
        #2 reset = 1'b1;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check_outputs("t6_async");
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_outputs("t6_release");
        step(1'b1, 8'h99, 1'b0, 1'b0, "t6_wr");

        // Random traffic alternating write-heavy and read-heavy phases
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 60; i++) begin
                bit wv, rr, clr;
                wv  = (p % 2 == 0) ? ($urandom_range(9, 0) < 8) : ($urandom_range(9, 0) < 3);
                rr  = (p % 2 == 0) ? ($urandom_range(9, 0) < 3) : ($urandom_range(9, 0) < 8);
                clr = ($urandom_range(99, 0) == 0);
                step(wv, 8'($urandom), rr, clr, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
